store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 102 ++++++++++
 tb/tb_store_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory.
// Stores are queued and drained in idle cycles; loads forward from the youngest entry.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              data_i,
    input  logic                     MemRead_i,
    input  logic                     MemWrite_i,
    output logic [31:0]              data_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_data_o,
    output logic                     mem_MemRead_o,
    output logic                     mem_MemWrite_o,
    input  logic [31:0]              mem_data_i
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW:0]   head_q, head_d;
    logic [PW:0]   tail_q, tail_d;
    logic [PW:0]   cnt;
    logic [PW-1:0] head_idx, tail_idx, scan_idx;
    logic          full, load, store, enq, drain;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign cnt      = tail_q - head_q;
    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];
    assign full     = (cnt == FULL_CNT);

    // A cycle with both requests is a store; raw MemRead_i still blocks draining.
    assign load  = MemRead_i & ~MemWrite_i & ~rst_i;
    assign store = MemWrite_i & ~rst_i;
    assign enq   = store & ~full;
    assign drain = ~rst_i & ~MemRead_i & (cnt != '0);

    assign head_d = drain ? head_q + ONE : head_q;
    assign tail_d = enq ? tail_q + ONE : tail_q;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + PW'(i);
            if (((PW+1)'(i) < cnt) && (addr_q[scan_idx] == addr_i[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[scan_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_idx] <= addr_i[31:2];
            data_q[tail_idx] <= data_i;
        end
    end

    always_comb begin
        mem_addr_o = '0;
        if (load) begin
            mem_addr_o = {addr_i[31:2], 2'b00};
        end else if (drain) begin
            mem_addr_o = {addr_q[head_idx], 2'b00};
        end
    end

    assign mem_data_o     = drain ? data_q[head_idx] : '0;
    assign mem_MemRead_o  = load;
    assign mem_MemWrite_o = drain;
    assign stall_o        = store & full;
    assign count_o        = cnt;
    assign empty_o        = (cnt == '0);
    assign data_o         = load ? (fwd_hit ? fwd_data : mem_data_i) : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_i;
    logic [31:0]            addr_i, data_i;
    logic                   MemRead_i, MemWrite_i;
    logic [31:0]            data_o;
    logic                   stall_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   empty_o;
    logic [31:0]            mem_addr_o, mem_data_o;
    logic                   mem_MemRead_o, mem_MemWrite_o;
    logic [31:0]            mem_data_i;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .addr_i         (addr_i),
        .data_i         (data_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .data_o         (data_o),
        .stall_o        (stall_o),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_MemRead_o  (mem_MemRead_o),
        .mem_MemWrite_o (mem_MemWrite_o),
        .mem_data_i     (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT, plus a log of every write it performs.
    logic [31:0] mem [256];
    logic [63:0] wlog [$];
    logic        mem_clr;

    assign mem_data_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h55;
        end else if (mem_MemWrite_o) begin
            mem[mem_addr_o[9:2]] <= mem_data_o;
            wlog.push_back({mem_addr_o, mem_data_o});
        end
    end

    // Reference model: pending stores as a queue, memory as an array.
    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q [$];
    logic [31:0] ref_mem [256];

    logic        e_stall, e_mrd, e_mwr;
    int          e_cnt;
    logic [31:0] e_maddr, e_mdata, e_dout;

    int ncmp = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("stall", 32'(stall_o), 32'(e_stall));
        chk("count", 32'(count_o), 32'(e_cnt));
        chk("empty", 32'(empty_o), 32'(e_cnt == 0));
        chk("data_o", data_o, e_dout);
        chk("mem_rd", 32'(mem_MemRead_o), 32'(e_mrd));
        chk("mem_wr", 32'(mem_MemWrite_o), 32'(e_mwr));
        chk("mem_addr", mem_addr_o, e_maddr);
        chk("mem_data", mem_data_o, e_mdata);
    endtask

    // Drive one cycle at the falling edge, evaluate the model, optionally
    // compare, then advance the model to the state after the next rising edge.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input bit cmp);
        logic ld, dr, fl;
        int   n;
        @(negedge clk);
        rst_i = r; MemRead_i = rd; MemWrite_i = wr; addr_i = a; data_i = d;
        #2;
        n  = q.size();
        fl = (n == DEPTH);
        ld = rd && !wr && !r;
        dr = !r && !rd && (n > 0);
        e_cnt   = n;
        e_stall = !r && wr && fl;
        e_mrd   = ld;
        e_mwr   = dr;
        e_maddr = 32'h0;
        e_mdata = 32'h0;
        e_dout  = 32'h0;
        if (ld) begin
            e_maddr = {a[31:2], 2'b00};
            e_dout  = ref_mem[a[9:2]];
            foreach (q[i]) if (q[i].a == a[31:2]) e_dout = q[i].d;
        end else if (dr) begin
            e_maddr = {q[0].a, 2'b00};
            e_mdata = q[0].d;
        end
        if (cmp) check_model();
        if (r) begin
            q.delete();
        end else begin
            if (dr) begin
                ref_mem[q[0].a[7:0]] = q[0].d;
                q.delete(0);
            end
            if (wr && !fl) q.push_back({a[31:2], d});
        end
    endtask

    typedef struct {
        logic        r, rd, wr;
        logic [31:0] a, d;
        logic        stall;
        int          cnt;
        logic        mrd, mwr;
        logic [31:0] maddr, dout;
    } vec_t;

    function automatic vec_t mk(logic r, logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                                logic stall, int cnt, logic mrd, logic mwr,
                                logic [31:0] maddr, logic [31:0] dout);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.stall = stall; v.cnt = cnt; v.mrd = mrd; v.mwr = mwr;
        v.maddr = maddr; v.dout = dout;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        int L0;
        rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = 32'h0; data_i = 32'h0;
        mem_clr = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[2] = 32'h55;
        @(posedge clk);
        #1 mem_clr = 1'b0;

        //          r rd wr addr      data           st cnt mrd mwr maddr  dout
        tbl.push_back(mk(1, 0, 1, 32'h10, 32'h1234,     0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 1, 0, 1, 32'h10, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h20, 32'h11,       0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h22, 32'h22,       0, 1, 0, 1, 32'h20, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h20, 32'h0,        0, 1, 1, 0, 32'h20, 32'h22));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 1, 0, 1, 32'h20, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h0C, 32'h77,       0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0B, 32'h0,        0, 1, 1, 0, 32'h08, 32'h55));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 1, 0, 1, 32'h0C, 32'h0));
        tbl.push_back(mk(0, 1, 1, 32'h30, 32'h99,       0, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 1, 1, 32'h34, 32'h98,       0, 1, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h30, 32'h0,        0, 2, 1, 0, 32'h30, 32'h99));
        tbl.push_back(mk(0, 1, 0, 32'h40, 32'h0,        0, 2, 1, 0, 32'h40, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 2, 0, 1, 32'h30, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 1, 0, 1, 32'h34, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  32'h0));

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].rd, tbl[k].wr, tbl[k].a, tbl[k].d, 1'b0);
            chk($sformatf("tbl%0d_stall", k), 32'(stall_o), 32'(tbl[k].stall));
            chk($sformatf("tbl%0d_count", k), 32'(count_o), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d_empty", k), 32'(empty_o), 32'(tbl[k].cnt == 0));
            chk($sformatf("tbl%0d_mrd", k), 32'(mem_MemRead_o), 32'(tbl[k].mrd));
            chk($sformatf("tbl%0d_mwr", k), 32'(mem_MemWrite_o), 32'(tbl[k].mwr));
            chk($sformatf("tbl%0d_maddr", k), mem_addr_o, tbl[k].maddr);
            chk($sformatf("tbl%0d_dout", k), data_o, tbl[k].dout);
        end
        chk("mem_w4", mem[4], 32'hDEADBEEF);
        chk("mem_w8", mem[8], 32'h22);
        chk("mem_w3", mem[3], 32'h77);
        chk("mem_w12", mem[12], 32'h99);
        chk("mem_w13", mem[13], 32'h98);

        // Fill with drain blocked, stall on the fifth store, then release.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h300 + 32'(4 * i), 32'hC000 + 32'(i), 1'b1);
        step(0, 1, 1, 32'h310, 32'hC004, 1'b1);
        chk("full_stall", 32'(stall_o), 32'h1);
        chk("full_count", 32'(count_o), 32'h4);
        step(0, 0, 1, 32'h310, 32'hC004, 1'b1);
        chk("full_drain_stall", 32'(stall_o), 32'h1);
        chk("full_drain_wr", 32'(mem_MemWrite_o), 32'h1);
        step(0, 0, 1, 32'h310, 32'hC004, 1'b1);
        chk("held_accept", 32'(stall_o), 32'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        chk("held_in_mem", mem[196], 32'hC004);

        // Ten store/idle pairs wrap the pointers more than twice.
        L0 = wlog.size();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1);
            step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        end
        step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        chk("wrap_count", 32'(count_o), 32'h0);
        chk("wrap_nwrites", 32'(wlog.size() - L0), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (L0 + i < wlog.size()) begin
                chk($sformatf("wrap_addr%0d", i), wlog[L0 + i][63:32], 32'h200 + 32'(4 * i));
                chk($sformatf("wrap_data%0d", i), wlog[L0 + i][31:0], 32'hA000 + 32'(i));
            end
        end

        // Reset with three entries pending discards them.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h100 + 32'(4 * i), 32'hB000 + 32'(i), 1'b1);
        step(1, 0, 1, 32'h10C, 32'hB003, 1'b1);
        chk("rst_no_write", 32'(mem_MemWrite_o), 32'h0);
        chk("rst_no_stall", 32'(stall_o), 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        chk("rst_count", 32'(count_o), 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_unwritten%0d", i), mem[64 + i], 32'h0);

        // Random traffic over a small address window to exercise forwarding.
        for (int it = 0; it < 600; it++) begin
            int          sel;
            logic [31:0] a;
            a   = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 49) == 0) step(1, 1'($urandom), 1'($urandom), a, $urandom, 1'b1);
            else if (sel < 4) step(0, 0, 1, a, $urandom, 1'b1);
            else if (sel < 6) step(0, 1, 0, a, 32'h0, 1'b1);
            else if (sel == 6) step(0, 1, 1, a, $urandom, 1'b1);
            else step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 256; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
